// File: rtl/ictrl_ibuf_noc_reader.sv
// Streams noc_wr_ibuffer_word_num ibuffer words out as a req/ready flit stream,
// prefetching through a small credited FIFO; first beat 2 cycles after start.
module ictrl_ibuf_noc_reader #(
  parameter int FLIT_WIDTH = 32,
  parameter int ADDR_W     = 17,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  noc_wr_start,
  input  logic [ADDR_W-1:0]     noc_wr_ibuffer_word_addr,
  input  logic [12:0]           noc_wr_ibuffer_word_num,
  output logic                  noc_wr_done,
  output logic                  noc_wr_req,
  input  logic                  noc_wr_ready,
  output logic [FLIT_WIDTH-1:0] noc_wr_data,
  output logic                  noc_wr_last,
  output logic                  ibuf_rd_en,
  output logic [ADDR_W-1:0]     ibuf_rd_addr,
  input  logic                  ibuf_rd_gnt,
  input  logic [FLIT_WIDTH-1:0] ibuf_rd_rdata
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [12:0]           rd_left_q, rd_left_d;
  logic [12:0]           beat_left_q, beat_left_d;
  logic                  inflight_q, inflight_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [PW-1:0]         wp_q, wp_d, rp_q, rp_d;
  logic [FLIT_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic          accept, hs, fifo_empty, wr_en;
  logic [CW-1:0] occ;

  // Returning read data bypasses an empty FIFO so the first beat leaves with it.
  assign fifo_empty   = (cnt_q == '0);
  assign occ          = cnt_q + CW'(inflight_q);
  assign ibuf_rd_en   = (state_q == ST_RUN) && (rd_left_q != 13'd0) && (occ < CW'(FIFO_DEPTH));
  assign ibuf_rd_addr = addr_q;
  assign accept       = ibuf_rd_en && ibuf_rd_gnt;
  assign noc_wr_req   = !fifo_empty || inflight_q;
  assign noc_wr_data  = !noc_wr_req ? '0 : (fifo_empty ? ibuf_rd_rdata : mem_q[rp_q]);
  assign noc_wr_last  = noc_wr_req && (beat_left_q == 13'd1);
  assign noc_wr_done  = (state_q == ST_DONE);
  assign hs           = noc_wr_req && noc_wr_ready;
  assign wr_en        = inflight_q && !(hs && fifo_empty);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rd_left_d   = rd_left_q;
    beat_left_d = beat_left_q - {12'd0, hs};
    inflight_d  = accept;
    cnt_d       = cnt_q + CW'(inflight_q) - CW'(hs);
    wp_d        = wr_en ? wp_q + PW'(1) : wp_q;
    rp_d        = (hs && !fifo_empty) ? rp_q + PW'(1) : rp_q;
    case (state_q)
      ST_IDLE: begin
        if (noc_wr_start) begin
          addr_d      = noc_wr_ibuffer_word_addr;
          rd_left_d   = noc_wr_ibuffer_word_num;
          beat_left_d = noc_wr_ibuffer_word_num;
          state_d     = (noc_wr_ibuffer_word_num != 13'd0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        if (accept) begin
          addr_d    = addr_q + ADDR_W'(1);
          rd_left_d = rd_left_q - 13'd1;
          if (rd_left_q == 13'd1) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (hs && noc_wr_last) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      rd_left_q   <= '0;
      beat_left_q <= '0;
      inflight_q  <= 1'b0;
      cnt_q       <= '0;
      wp_q        <= '0;
      rp_q        <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rd_left_q   <= rd_left_d;
      beat_left_q <= beat_left_d;
      inflight_q  <= inflight_d;
      cnt_q       <= cnt_d;
      wp_q        <= wp_d;
      rp_q        <= rp_d;
    end
  end

  // Storage needs no reset: the output mux zeroes data whenever req is low.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wp_q] <= ibuf_rd_rdata;
  end

endmodule

// File: tb/tb_ictrl_ibuf_noc_reader.sv
// Directed bench for ictrl_ibuf_noc_reader: vector table of transfers plus reset corner cases.
module tb_ictrl_ibuf_noc_reader;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [16:0] waddr;
  logic [12:0] wnum;
  logic        done, req, ready, last, rd_en, gnt;
  logic [31:0] data, rdata;
  logic [16:0] rd_addr;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [16:0] addr;
    int          num;
    int          gmode;    // 0: gnt always high, 1: gnt high on odd cycles
    int          rmode;    // 0: ready always high, 1: ready low 10 cycles after first beat
    int          restart;  // 1: pulse start again at cycle 5
    int          exp_cyc;  // cycle of done relative to start cycle, -1 = not fixed
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;

  ictrl_ibuf_noc_reader #(.FLIT_WIDTH(32), .ADDR_W(17), .FIFO_DEPTH(DEPTH)) dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .noc_wr_start             (start),
    .noc_wr_ibuffer_word_addr (waddr),
    .noc_wr_ibuffer_word_num  (wnum),
    .noc_wr_done              (done),
    .noc_wr_req               (req),
    .noc_wr_ready             (ready),
    .noc_wr_data              (data),
    .noc_wr_last              (last),
    .ibuf_rd_en               (rd_en),
    .ibuf_rd_addr             (rd_addr),
    .ibuf_rd_gnt              (gnt),
    .ibuf_rd_rdata            (rdata)
  );

  function automatic logic [31:0] word(input logic [16:0] a);
    return {a[14:0], a};
  endfunction

  // Ibuffer model: data valid exactly one cycle after an accepted read, junk otherwise.
  always @(posedge clk) begin
    if (rd_en && gnt) rdata <= word(rd_addr);
    else              rdata <= 32'hDEAD_BEEF;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, " done"}, {31'd0, done}, 32'd0);
    chk({tag, " req"}, {31'd0, req}, 32'd0);
    chk({tag, " last"}, {31'd0, last}, 32'd0);
    chk({tag, " rd_en"}, {31'd0, rd_en}, 32'd0);
    chk({tag, " rd_addr"}, {15'd0, rd_addr}, 32'd0);
    chk({tag, " data"}, data, 32'd0);
  endtask

  task automatic run_xfer(input vec_t v, input string tag);
    int cyc, beats, accs, dones, done_cyc, fb, overfill;
    logic [16:0] ea;
    beats = 0; accs = 0; dones = 0; done_cyc = -1; fb = -1; overfill = 0;
    @(posedge clk); #1;
    start = 1'b1; waddr = v.addr; wnum = 13'(v.num); gnt = 1'b1; ready = 1'b1;
    for (cyc = 0; cyc < 400; cyc++) begin
      if (cyc > 0) begin
        @(posedge clk); #1;
        start = (v.restart != 0) && (cyc == 5);
        waddr = start ? 17'h01000 : v.addr;
        wnum  = start ? 13'd3 : 13'(v.num);
        gnt   = (v.gmode == 1) ? (cyc % 2 == 1) : 1'b1;
        ready = !(v.rmode == 1 && fb >= 0 && cyc > fb && cyc <= fb + 10);
      end
      @(negedge clk);
      if (rd_en && gnt) begin
        ea = v.addr + 17'(accs);
        chk($sformatf("%s rd_addr[%0d]", tag, accs), {15'd0, rd_addr}, {15'd0, ea});
        accs++;
      end
      if (req) begin
        ea = v.addr + 17'(beats);
        chk($sformatf("%s data[%0d]", tag, beats), data, word(ea));
        chk($sformatf("%s last[%0d]", tag, beats), {31'd0, last}, {31'd0, beats == v.num - 1});
        if (ready) begin
          beats++;
          if (fb < 0) fb = cyc;
        end
      end
      if (accs - beats > DEPTH) overfill++;
      if (done) begin
        dones++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
    end
    start = 1'b0;
    chk({tag, " reads"}, 32'(accs), 32'(v.num));
    chk({tag, " beats"}, 32'(beats), 32'(v.num));
    chk({tag, " done pulses"}, 32'(dones), 32'd1);
    chk({tag, " buffered>depth"}, 32'(overfill), 32'd0);
    if (v.exp_cyc >= 0) chk({tag, " done cycle"}, 32'(done_cyc), 32'(v.exp_cyc));
    else                chk({tag, " done seen"}, {31'd0, done_cyc >= 0}, 32'd1);
  endtask

  initial begin
    //           addr       num gm rm rs exp
    vecs[0] = '{17'h00100, 16, 0, 0, 0, 18};
    vecs[1] = '{17'h1FFFE,  4, 0, 0, 0,  6};
    vecs[2] = '{17'h00200, 32, 0, 1, 0, 44};
    vecs[3] = '{17'h00300, 16, 1, 0, 0, -1};
    vecs[4] = '{17'h00050,  0, 0, 0, 0,  1};
    vecs[5] = '{17'h00400,  8, 0, 0, 1, 10};
    vecs[6] = '{17'h1FFFF,  1, 0, 0, 0,  3};

    rst_n = 1'b0; start = 1'b0; waddr = '0; wnum = '0; gnt = 1'b1; ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_outputs_zero("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_xfer(vecs[i], $sformatf("vec%0d", i));

    // Reset mid-RUN with a read accepted right before it; its data must not surface.
    @(posedge clk); #1;
    start = 1'b1; waddr = 17'h00040; wnum = 13'd32; gnt = 1'b1; ready = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk_outputs_zero("midrst");
    @(negedge clk);
    chk("midrst req after", {31'd0, req}, 32'd0);
    run_xfer(vecs[0], "post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
